// File: rtl/act_gather_pp.sv
// Ping-pong activation gatherer: packs a serial element stream into IN-wide frames
// for the FC layer, holding one frame stable while the next one fills.
module act_gather_pp #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_x [0:IN-1],
    output logic             frame_err
);

    localparam int CW = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

    logic [WIDTH-1:0] bank0_q [0:IN-1];
    logic [WIDTH-1:0] bank1_q [0:IN-1];
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic             frame_err_q, frame_err_d;

    logic accept;
    logic release_rd;
    logic last_slot;

    // Both handshake outputs come only from registers, so neither side sees
    // a combinational path from the other.
    assign s_ready    = ~full_q[wr_sel_q];
    assign m_valid    = full_q[rd_sel_q];
    assign frame_err  = frame_err_q;
    assign accept     = s_valid & s_ready;
    assign release_rd = m_valid & m_ready;
    assign last_slot  = (wr_cnt_q == LAST_IDX);

    always_comb begin
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_cnt_d    = wr_cnt_q;
        frame_err_d = frame_err_q;
        // When a release and a completion coincide they hit different banks,
        // so applying both in sequence is safe.
        if (release_rd) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        if (accept) begin
            if (last_slot) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                wr_cnt_d         = '0;
                if (!s_last) frame_err_d = 1'b1;
            end else if (s_last) begin
                // Early end: discard the partial frame by rewinding in place.
                wr_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            full_q      <= 2'b00;
            wr_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            full_q      <= full_d;
            wr_cnt_q    <= wr_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else if (accept) begin
            if (wr_sel_q) bank1_q[wr_cnt_q] <= s_data;
            else          bank0_q[wr_cnt_q] <= s_data;
        end
    end

    always_comb begin
        for (int k = 0; k < IN; k++) begin
            m_x[k] = rd_sel_q ? bank1_q[k] : bank0_q[k];
        end
    end

endmodule
